// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-look-ahead adder/subtractor with valid/ready handshake
//
// Purpose:
//   Adds or subtracts two WIDTH-bit operands, processing one BLK-bit
//   look-ahead group per pipeline stage (NSTG = WIDTH/BLK stages). The carry
//   between groups is registered, so one operation is accepted per cycle and
//   the result appears NSTG cycles later when the sink is not stalling.
//
// Optional feature:
//   CLA_PIPE_SAT_EN - when defined, a signed overflow clamps s to the most
//   positive / most negative value in the final stage.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand beat valid
//   in_ready   out  pipe can accept a beat this cycle
//   x, y       in   operands A and B (WIDTH)
//   cin        in   carry-in, ignored when sub=1
//   sub        in   1: x - y, 0: x + y + cin
//   out_valid  out  result beat valid
//   out_ready  in   sink accepts the result
//   s          out  sum / difference (WIDTH)
//   cout       out  carry out of the MSB (for sub, 1 = no borrow)
//   ovf        out  two's-complement signed overflow
//   zero       out  s == 0
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTG = WIDTH / BLK;

  generate
    if (((WIDTH % BLK) != 0) || (WIDTH < BLK)) begin : g_bad_cfg
      $error("cla_pipe_adder: WIDTH must be a non-zero multiple of BLK");
    end
  endgenerate

  // Carries c[0..BLK] of one group in sum-of-products look-ahead form:
  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci, no ripple between bits.
  function automatic logic [BLK:0] lookahead(input logic [BLK-1:0] p,
                                             input logic [BLK-1:0] g,
                                             input logic           ci);
    logic [BLK:0] c;
    logic         acc;
    logic         term;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLK; i++) begin
      acc = ci;
      for (int j = 0; j <= i; j++) begin
        acc = acc & p[j];
      end
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) begin
          term = term & p[m];
        end
        acc = acc | term;
      end
      c[i+1] = acc;
    end
    return c;
  endfunction

  // Per-stage state: valid bit, operands (upper bits still to be processed),
  // skewed sum bits computed so far, and the group carry-out.
  logic             vld_q [NSTG];
  logic             vld_d [NSTG];
  logic [WIDTH-1:0] x_q   [NSTG];
  logic [WIDTH-1:0] x_d   [NSTG];
  logic [WIDTH-1:0] y_q   [NSTG];
  logic [WIDTH-1:0] y_d   [NSTG];
  logic [WIDTH-1:0] sum_q [NSTG];
  logic [WIDTH-1:0] sum_d [NSTG];
  logic             c_q   [NSTG];
  logic             c_d   [NSTG];

  logic cout_q, cout_d;
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;
  logic adv;

  assign out_valid = vld_q[NSTG-1];
  // The whole pipe moves as one unit; a stalled output freezes every stage.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && !rst;

  assign s    = sum_q[NSTG-1];
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

  always_comb begin
    logic [WIDTH-1:0] sx;
    logic [WIDTH-1:0] sy;
    logic [WIDTH-1:0] ssum;
    logic             sc;
    logic             sv;
    logic [BLK-1:0]   xg;
    logic [BLK-1:0]   yg;
    logic [BLK-1:0]   pg;
    logic [BLK-1:0]   gg;
    logic [BLK:0]     cg;
    int               km1;

    sx     = '0;
    sy     = '0;
    ssum   = '0;
    sc     = 1'b0;
    sv     = 1'b0;
    xg     = '0;
    yg     = '0;
    pg     = '0;
    gg     = '0;
    cg     = '0;
    km1    = 0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    zero_d = 1'b0;

    for (int k = 0; k < NSTG; k++) begin
      km1 = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        // Subtraction is x + ~y + 1.
        sx   = x;
        sy   = sub ? ~y : y;
        sc   = sub ? 1'b1 : cin;
        ssum = '0;
        sv   = in_valid;
      end else begin
        sx   = x_q[km1];
        sy   = y_q[km1];
        sc   = c_q[km1];
        ssum = sum_q[km1];
        sv   = vld_q[km1];
      end

      xg = sx[k*BLK +: BLK];
      yg = sy[k*BLK +: BLK];
      pg = xg ^ yg;
      gg = xg & yg;
      cg = lookahead(pg, gg, sc);
      ssum[k*BLK +: BLK] = pg ^ cg[BLK-1:0];

      if (k == NSTG - 1) begin
        cout_d = cg[BLK];
        ovf_d  = cg[BLK] ^ cg[BLK-1];
`ifdef CLA_PIPE_SAT_EN
        // On overflow both operand signs agree; a clear sign means the true
        // result was positive.
        if (ovf_d) begin
          ssum = xg[BLK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        zero_d = ~|ssum;
      end

      vld_d[k] = sv;
      x_d[k]   = sx;
      y_d[k]   = sy;
      sum_d[k] = ssum;
      c_d[k]   = cg[BLK];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) begin
        vld_q[k] <= 1'b0;
        x_q[k]   <= '0;
        y_q[k]   <= '0;
        sum_q[k] <= '0;
        c_q[k]   <= 1'b0;
      end
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NSTG; k++) begin
        vld_q[k] <= vld_d[k];
        x_q[k]   <= x_d[k];
        y_q[k]   <= y_d[k];
        sum_q[k] <= sum_d[k];
        c_q[k]   <= c_d[k];
      end
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

endmodule
